// File: rtl/lstm_pkg.sv
// Shared constants for the LSTM parameter memories: bank ids, bank depths,
// loader header layout and the loader framing states.
package lstm_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int LUT_DEPTH   = 16;
    localparam int WLSTM_DEPTH = 64;
    localparam int ULSTM_DEPTH = 32;
    localparam int BLSTM_DEPTH = 16;
    localparam int WFC_DEPTH   = 4;
    localparam int BFC_DEPTH   = 1;

    localparam logic [2:0] SEL_SIGMOID = 3'd0;
    localparam logic [2:0] SEL_TANH    = 3'd1;
    localparam logic [2:0] SEL_WLSTM   = 3'd2;
    localparam logic [2:0] SEL_ULSTM   = 3'd3;
    localparam logic [2:0] SEL_BLSTM   = 3'd4;
    localparam logic [2:0] SEL_WFC     = 3'd5;
    localparam logic [2:0] SEL_BFC     = 3'd6;
    localparam logic [3:0] NUM_BANKS   = 4'd7;

    localparam int HDR_ID_MSB = 31;
    localparam int HDR_ID_LSB = 28;
    localparam int HDR_N_MSB  = 15;
    localparam int HDR_N_LSB  = 0;

    typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_CHK} state_t;

    // Ids 7..15 name no bank and report depth 0.
    function automatic logic [15:0] bank_depth(input logic [3:0] id);
        logic [15:0] depth;
        case (id)
            {1'b0, SEL_SIGMOID}, {1'b0, SEL_TANH}: depth = 16'(LUT_DEPTH);
            {1'b0, SEL_WLSTM}:                     depth = 16'(WLSTM_DEPTH);
            {1'b0, SEL_ULSTM}:                     depth = 16'(ULSTM_DEPTH);
            {1'b0, SEL_BLSTM}:                     depth = 16'(BLSTM_DEPTH);
            {1'b0, SEL_WFC}:                       depth = 16'(WFC_DEPTH);
            {1'b0, SEL_BFC}:                       depth = 16'(BFC_DEPTH);
            default:                               depth = 16'd0;
        endcase
        return depth;
    endfunction

endpackage

// File: rtl/lstm_param_loader.sv
// Framed word-stream loader for the seven LSTM parameter banks: header, bounded
// payload writes, XOR checksum, and a per-bank verified-image mask.
module lstm_param_loader
    import lstm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  wr_en,
    output logic [2:0]            wr_sel,
    output logic [5:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [6:0]            loaded,
    output logic                  all_loaded,
    output logic                  err
);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_id;
    logic [15:0]           r_n;
    logic [15:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_xor;
    logic                  r_wr_en;
    logic [2:0]            r_wr_sel;
    logic [5:0]            r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [6:0]            r_loaded;
    logic                  r_all_loaded;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_wr_en;
    logic                  w_err_set;
    logic                  w_set_loaded;
    logic                  w_clr_loaded;
    logic [3:0]            w_hdr_id;
    logic [15:0]           w_hdr_n;
    logic [15:0]           w_depth;

    // The loader never backpressures; only reset blocks the stream.
    assign s_ready  = ~rst;
    assign w_accept = s_valid & ~rst;
    assign w_hdr_id = s_data[HDR_ID_MSB:HDR_ID_LSB];
    assign w_hdr_n  = s_data[HDR_N_MSB:HDR_N_LSB];
    assign w_depth  = bank_depth(r_id);

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_err_set    = 1'b0;
        w_set_loaded = 1'b0;
        w_clr_loaded = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_HDR: begin
                    if (w_hdr_id < NUM_BANKS) w_clr_loaded = 1'b1;
                    else                      w_err_set    = 1'b1;
                    w_state_next = (w_hdr_n != 16'd0) ? ST_DATA : ST_CHK;
                end
                ST_DATA: begin
                    if ((r_id < NUM_BANKS) && (r_addr < w_depth)) w_wr_en   = 1'b1;
                    else                                          w_err_set = 1'b1;
                    if (r_addr == (r_n - 16'd1)) w_state_next = ST_CHK;
                end
                ST_CHK: begin
                    // A matching checksum only verifies an image that fills the bank exactly.
                    if ((s_data == r_xor) && (r_id < NUM_BANKS) && (r_n == w_depth))
                        w_set_loaded = 1'b1;
                    else
                        w_err_set = 1'b1;
                    w_state_next = ST_HDR;
                end
                default: w_state_next = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HDR;
            r_id         <= 4'd0;
            r_n          <= 16'd0;
            r_addr       <= 16'd0;
            r_xor        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_sel     <= 3'd0;
            r_wr_addr    <= 6'd0;
            r_wr_data    <= '0;
            r_loaded     <= 7'd0;
            r_all_loaded <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_en      <= w_wr_en;
            r_all_loaded <= &r_loaded;
            if (w_wr_en) begin
                r_wr_sel  <= r_id[2:0];
                r_wr_addr <= r_addr[5:0];
                r_wr_data <= s_data;
            end
            if (w_err_set)    r_err                    <= 1'b1;
            if (w_clr_loaded) r_loaded[w_hdr_id[2:0]]  <= 1'b0;
            if (w_set_loaded) r_loaded[r_id[2:0]]      <= 1'b1;
            if (w_accept) begin
                case (r_state)
                    ST_HDR: begin
                        r_id   <= w_hdr_id;
                        r_n    <= w_hdr_n;
                        r_addr <= 16'd0;
                        r_xor  <= '0;
                    end
                    ST_DATA: begin
                        r_addr <= r_addr + 16'd1;
                        r_xor  <= r_xor ^ s_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_sel     = r_wr_sel;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign loaded     = r_loaded;
    assign all_loaded = r_all_loaded;
    assign err        = r_err;

endmodule

// File: tb/tb_lstm_param_loader.sv
// Self-checking bench for lstm_param_loader: frame-level reference model with a
// per-cycle compare process, plus literal checks from the directed scenarios.
module tb_lstm_param_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  loaded;
    logic        all_loaded;
    logic        err;

    always #5 clk = ~clk;

    lstm_param_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .loaded     (loaded),
        .all_loaded (all_loaded),
        .err        (err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [40:0] expWrites[$];
    logic [40:0] expW;
    logic [40:0] lastWr = '0;
    logic [6:0]  expLoaded = 7'd0;
    logic        expErr = 1'b0;
    logic        lastAnd = 1'b0;
    int          writeCount = 0;
    int          covCount[7][64];
    logic [31:0] payload[$];

    function automatic int depthOf(input int id);
        int depths[7] = '{16, 16, 64, 32, 16, 4, 1};
        if (id < 0 || id > 6) return 0;
        return depths[id];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Registered outputs are compared mid-cycle against the model state left by the driver.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("s_ready_in_reset", 64'(s_ready), 64'd0);
            lastAnd = 1'b0;
        end else begin
            checkOutput("s_ready", 64'(s_ready), 64'd1);
            checkOutput("loaded", 64'(loaded), 64'(expLoaded));
            checkOutput("err", 64'(err), 64'(expErr));
            checkOutput("all_loaded", 64'(all_loaded), 64'(lastAnd));
            lastAnd = &expLoaded;
            if (wr_en) begin
                writeCount++;
                lastWr = {wr_sel, wr_addr, wr_data};
                if (wr_sel < 3'd7) covCount[wr_sel][wr_addr]++;
                checkOutput("write_expected", 64'(expWrites.size() > 0), 64'd1);
                if (expWrites.size() > 0) begin
                    expW = expWrites.pop_front();
                    checkOutput("write", 64'({wr_sel, wr_addr, wr_data}), 64'(expW));
                end
            end
            checkOutput("missing_write", 64'(expWrites.size()), 64'd0);
            expWrites.delete();
        end
    end

    task automatic applyStimulus(input logic [31:0] word);
        repeat ($urandom_range(0, 2)) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = word;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic fillPayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back($urandom);
    endtask

    // abortAfter >= 0 stops the frame after that many payload words.
    task automatic sendFrame(input int id, input int n, input logic [31:0] flip, input int abortAfter);
        logic [31:0] x;
        logic [3:0]  idBits;
        logic [15:0] nBits;
        x      = 32'd0;
        idBits = 4'(id);
        nBits  = 16'(n);
        applyStimulus({idBits, 12'($urandom), nBits});
        if (id < 7) expLoaded[id] = 1'b0;
        else        expErr = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == abortAfter) return;
            applyStimulus(payload[i]);
            x ^= payload[i];
            if (i < depthOf(id)) expWrites.push_back({idBits[2:0], 6'(i), payload[i]});
            else                 expErr = 1'b1;
        end
        applyStimulus(x ^ flip);
        if (flip == 32'd0 && id < 7 && n == depthOf(id)) expLoaded[id] = 1'b1;
        else                                             expErr = 1'b1;
    endtask

    task automatic doReset();
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        expLoaded = 7'd0;
        expErr    = 1'b0;
        expWrites.delete();
    endtask

    initial begin
        int w0;
        int good;
        int id;
        int n;
        for (int b = 0; b < 7; b++) for (int a = 0; a < 64; a++) covCount[b][a] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_loaded", 64'(loaded), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
        checkOutput("reset_wr_bus", 64'({wr_sel, wr_addr, wr_data}), 64'd0);

        // Single-word b_fc image.
        w0 = writeCount;
        payload.delete();
        payload.push_back(32'h3F80_0000);
        sendFrame(6, 1, 32'd0, -1);
        checkOutput("bfc_write_count", 64'(writeCount - w0), 64'd1);
        checkOutput("bfc_write", 64'(lastWr), 64'({3'd6, 6'd0, 32'h3F80_0000}));
        checkOutput("bfc_loaded", 64'(loaded), 64'b100_0000);
        checkOutput("bfc_err", 64'(err), 64'd0);

        // Every bank in order, with random stalls.
        for (int b = 0; b < 7; b++) for (int a = 0; a < 64; a++) covCount[b][a] = 0;
        for (int b = 0; b < 7; b++) begin
            fillPayload(depthOf(b));
            sendFrame(b, depthOf(b), 32'd0, -1);
        end
        @(negedge clk);
        checkOutput("all_banks_loaded", 64'(loaded), 64'h7F);
        checkOutput("all_loaded_lag", 64'(all_loaded), 64'd0);
        @(negedge clk);
        checkOutput("all_loaded_set", 64'(all_loaded), 64'd1);
        @(posedge clk); #1;
        for (int b = 0; b < 7; b++) begin
            good = 0;
            for (int a = 0; a < 64; a++)
                if (covCount[b][a] == ((a < depthOf(b)) ? 1 : 0)) good++;
            checkOutput($sformatf("coverage_bank%0d", b), 64'(good), 64'd64);
        end

        // w_fc overrun: N = 6 against depth 4.
        w0 = writeCount;
        fillPayload(6);
        sendFrame(5, 6, 32'd0, -1);
        checkOutput("wfc_overrun_writes", 64'(writeCount - w0), 64'd4);
        checkOutput("wfc_overrun_err", 64'(err), 64'd1);
        checkOutput("wfc_overrun_loaded5", 64'(loaded[5]), 64'd0);

        // w_lstm with a single-bit checksum error.
        w0 = writeCount;
        fillPayload(64);
        sendFrame(2, 64, 32'h0000_0100, -1);
        checkOutput("wlstm_badchk_writes", 64'(writeCount - w0), 64'd64);
        checkOutput("wlstm_badchk_loaded2", 64'(loaded[2]), 64'd0);

        // Invalid id 9 consumes its whole frame with no writes.
        doReset();
        w0 = writeCount;
        fillPayload(3);
        sendFrame(9, 3, 32'd0, -1);
        checkOutput("bad_id_writes", 64'(writeCount - w0), 64'd0);
        checkOutput("bad_id_err", 64'(err), 64'd1);
        fillPayload(16);
        sendFrame(0, 16, 32'd0, -1);
        checkOutput("after_bad_id_loaded", 64'(loaded), 64'b000_0001);

        // Reset mid u_lstm frame, then a full reload.
        fillPayload(32);
        sendFrame(3, 32, 32'd0, 10);
        doReset();
        checkOutput("midreset_loaded", 64'(loaded), 64'd0);
        checkOutput("midreset_err", 64'(err), 64'd0);
        fillPayload(32);
        sendFrame(3, 32, 32'd0, -1);
        checkOutput("ulstm_reload_loaded", 64'(loaded), 64'b000_1000);
        checkOutput("ulstm_reload_err", 64'(err), 64'd0);

        // Randomised frames: exact, short, long, invalid ids, corrupt checksums, resets.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0) doReset();
            id = $urandom_range(0, 8);
            case ($urandom_range(0, 3))
                0:       n = depthOf(id) + 1;
                1:       n = (depthOf(id) > 0) ? depthOf(id) - 1 : 0;
                default: n = depthOf(id);
            endcase
            if (id >= 7) n = $urandom_range(0, 5);
            fillPayload(n);
            sendFrame(id, n, ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("write_queue_drained", 64'(expWrites.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lstm_param_loader.md
# lstm_param_loader

Write-side companion to the LSTM inference top: accepts a word stream carrying activation LUTs and trained weights, and writes them into the seven parameter memories that the LSTM cells and FC stage read. A small framing FSM decodes a header, streams the payload into the selected bank with per-bank bound checking, and checks a trailing XOR checksum. It publishes a per-bank loaded mask so inference is gated until every bank holds a verified image.

## Interface
- DATA_WIDTH, 32: stream and memory word width.
- LUT_DEPTH, 16: depth of the sigmoid and tanh LUT banks.
- WLSTM_DEPTH, 64 / ULSTM_DEPTH, 32 / BLSTM_DEPTH, 16: LSTM W, U and bias bank depths.
- WFC_DEPTH, 4 / BFC_DEPTH, 1: FC weight and bias bank depths.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  header, payload or checksum word.
- wr_en  out  1  one-cycle memory write strobe.
- wr_sel  out  3  bank: 0 sigmoid_lut, 1 tanh_lut, 2 w_lstm, 3 u_lstm, 4 b_lstm, 5 w_fc, 6 b_fc.
- wr_addr  out  6  word address within the bank.
- wr_data  out  DATA_WIDTH  word to write.
- loaded  out  7  bit k set when bank k holds a complete, checksum-verified image.
- all_loaded  out  1  &loaded, registered.
- err  out  1  sticky error; cleared only by rst.

## Operation
- States: HDR, DATA, CHK.
- HDR: accepted word is the header. [31:28] = target id, [15:0] = N, other bits ignored. Latch id and N, clear addr and running XOR, clear loaded[id] if id < 7. Next state: DATA if N > 0, else CHK.
- DATA: each accepted word is XORed into the running checksum. If id < 7 and addr < depth(id), drive wr_en with wr_sel = id, wr_addr = addr, wr_data = word. Otherwise drop the word and set err. addr increments on every accepted word. After the N-th word, go to CHK.
- CHK: accepted word is compared with the running XOR. On a match with id < 7 and N == depth(id), set loaded[id]. On a mismatch, set err. A match with N ≠ depth(id) sets err and leaves loaded[id] clear. Return to HDR.
- Invalid id (7..15): the full frame (header, N payload words, checksum) is consumed with no writes, and err is set at the header.
- Reloading a bank clears its loaded bit at the header. The bit is set again only by a fresh verified frame. Frames for different banks may arrive in any order.
- s_ready is 0 in the cycle rst is asserted and 1 in every other cycle. The block never backpressures.

## Timing
- Reset values: state HDR, s_ready 0 during rst, wr_en 0, wr_sel 0, wr_addr 0, wr_data 0, loaded 0, all_loaded 0, err 0.
- Write latency: wr_* are registered and asserted in the cycle after the payload word is accepted. Back-to-back accepted words give back-to-back writes.
- loaded[id] updates in the cycle after the checksum word is accepted. all_loaded follows one cycle later.
- Idle cycles (s_valid = 0) are allowed anywhere in a frame. The FSM holds state and wr_en is 0.
- rst asserted mid-frame discards the partial frame, returns to HDR and clears loaded. Writes already issued are not undone; the bank stays unloaded until reloaded.
- Address counter is 16 bits internally so that N up to 65535 is consumed correctly. wr_addr carries its low 6 bits, which are only used when in bounds.

## Structure
- Shared package lstm_pkg: bank-id constants (SEL_SIGMOID … SEL_BFC), the depth constant set, the header field positions, and a function bank_depth(id) returning 0 for invalid ids.
- Single module. No sub-module; the checksum is one XOR register inside the FSM.

## Test plan
- Load b_fc with header 0x6000_0001, payload 0x3F80_0000, checksum 0x3F80_0000 -> one write (sel 6, addr 0, data 0x3F80_0000); loaded = 7'b100_0000; err = 0.
- Load all seven banks in order, each with correct checksums and stalls inserted -> writes cover every address 0..depth−1 exactly once; all_loaded = 1 one cycle after loaded = 7'h7F.
- w_fc frame with N = 6 and a valid checksum -> 4 writes (addr 0..3), 2 words dropped, err = 1, loaded[5] = 0.
- w_lstm frame with the checksum off by one bit -> 64 writes issued, loaded[2] = 0, err = 1.
- Header id = 9, N = 3, then 4 further words -> no wr_en, err = 1, and the next valid frame loads normally.
- rst asserted after 10 of 32 u_lstm payload words -> loaded = 0, state HDR, err = 0; a full u_lstm reload then sets loaded[3].
